if_fetch: RTL and testbench

- Instruction-fetch stage. It sits directly downstream of the branch unit's redirect outputs (br_e/br_addr) and upstream of decode.
- Holds the architectural fetch PC and issues requests to instruction memory over a req/addr_ok/data_ok handshake.
- Squashes wrong-path fetches on redirect.
- Buffers returned instructions in a small FIFO that feeds decode over a valid/ready handshake.

---
 rtl/if_fetch_pkg.sv | 16 +
 rtl/if_buffer.sv | 42 ++++
 rtl/if_fetch.sv | 82 ++++++++
 tb/tb_if_fetch.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
package if_fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_CANCEL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/if_buffer.sv
// Small circular instruction FIFO with occupancy count and single-cycle flush.
module if_buffer #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           rd_ptr, wr_ptr;

  assign head = mem[rd_ptr];

  // Storage, pointers and count; flush wins over push/pop. Pointers wrap naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one memory request
// in flight, squashes wrong-path responses on redirect and buffers fetched
// instructions for decode.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            br_e,
  input  logic [XLEN-1:0] br_addr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_addr_ok,
  input  logic            imem_data_ok,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_inst
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e    state;
  logic [XLEN-1:0] fetch_pc, req_pc, br_tgt;
  logic [CW-1:0]   buf_cnt;
  logic            accept, push, pop;
  fetch_entry_t    head;

  assign br_tgt    = {br_addr[XLEN-1:2], 2'b00};
  // Issue only with a free slot so the eventual response can always be pushed.
  assign imem_req  = resetn && (state == ST_REQ) && (buf_cnt < CW'(BUF_DEPTH));
  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_addr_ok;
  assign push      = (state == ST_WAIT) && imem_data_ok && !br_e;
  assign pop       = id_valid && id_ready && !br_e;
  assign id_valid  = (buf_cnt != '0);
  assign id_pc     = head.pc;
  assign id_inst   = head.inst;

  // Fetch FSM and PC; a redirect overrides everything and taints any accepted request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else if (br_e) begin
      fetch_pc <= br_tgt;
      unique case (state)
        ST_REQ:    state <= accept ? ST_CANCEL : ST_REQ;
        ST_WAIT:   state <= imem_data_ok ? ST_REQ : ST_CANCEL;
        default:   state <= imem_data_ok ? ST_REQ : ST_CANCEL;
      endcase
    end else begin
      unique case (state)
        ST_REQ: if (accept) begin
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + XLEN'(4);
          state    <= ST_WAIT;
        end
        ST_WAIT:   if (imem_data_ok) state <= ST_REQ;
        default:   if (imem_data_ok) state <= ST_REQ;
      endcase
    end
  end

  if_buffer #(
    .DEPTH (BUF_DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_buf (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data ({req_pc, imem_rdata}),
    .pop       (pop),
    .flush     (br_e),
    .count     (buf_cnt),
    .head      (head)
  );
endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch against a queue-based model of the fetch stream.
module tb_if_fetch;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        br_e;
  logic [31:0] br_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_addr_ok, imem_data_ok;
  logic [31:0] imem_rdata;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_inst;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(32'h8000_0000), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .br_e(br_e), .br_addr(br_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_addr_ok(imem_addr_ok),
    .imem_data_ok(imem_data_ok), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst)
  );

  int n_tests = 0, n_fail = 0;

  // model: queue of buffered PCs, expected next fetch address, outstanding request
  logic [31:0] q_pc[$];
  logic [31:0] exp_pc, out_addr;
  bit          outst, stale;
  int          lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] pick_target();
    case ($urandom_range(2))
      0:       return 32'h8000_0101;
      1:       return 32'hFFFF_FFF9;
      default: return $urandom;
    endcase
  endfunction

  task automatic model_reset();
    q_pc.delete();
    exp_pc = 32'h8000_0000;
    outst  = 0;
    stale  = 0;
    lat    = 0;
  endtask

  // One cycle: check outputs at negedge, drive inputs, advance the model.
  task automatic step(input int p_aok, input int max_lat, input int p_rdy, input int p_br);
    bit req_m, acc, pop_m;
    @(negedge clk);
    req_m = !outst && (q_pc.size() < DEPTH);
    chk("id_valid", 32'(id_valid), 32'(q_pc.size() != 0));
    if (q_pc.size() != 0) begin
      chk("id_pc", id_pc, q_pc[0]);
      chk("id_inst", id_inst, mem_word(q_pc[0]));
    end
    chk("imem_req", 32'(imem_req), 32'(req_m));
    if (req_m) chk("imem_addr", imem_addr, exp_pc);

    imem_addr_ok = ($urandom_range(99) < p_aok);
    imem_data_ok = outst && (lat == 0);
    imem_rdata   = imem_data_ok ? mem_word(out_addr) : $urandom;
    if (outst && lat > 0) lat--;
    id_ready = ($urandom_range(99) < p_rdy);
    br_e     = ($urandom_range(99) < p_br);
    br_addr  = pick_target();

    acc   = req_m && imem_addr_ok;
    pop_m = (q_pc.size() != 0) && id_ready && !br_e;
    if (pop_m) void'(q_pc.pop_front());
    if (imem_data_ok) begin
      if (!stale && !br_e) q_pc.push_back(out_addr);
      outst = 0;
    end
    if (acc) begin
      outst    = 1;
      stale    = br_e;
      out_addr = exp_pc;
      lat      = $urandom_range(max_lat - 1);
    end
    if (br_e) begin
      q_pc.delete();
      stale  = 1;
      exp_pc = {br_addr[31:2], 2'b00};
    end else if (acc) begin
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    br_e = 0; imem_addr_ok = 0; imem_data_ok = 0; id_ready = 0;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_inst", id_inst, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; br_e = 0; br_addr = '0; imem_addr_ok = 0;
    imem_data_ok = 0; imem_rdata = '0; id_ready = 0;
    model_reset();
    do_reset();
    // streaming: addr_ok always, data one cycle later, decode always ready
    repeat (30)  step(100, 1, 100, 0);
    // decode stalled: buffer fills and requests stop, then drain
    repeat (12)  step(100, 1, 0, 0);
    repeat (12)  step(100, 1, 100, 0);
    // random handshakes, occasional redirects
    repeat (800) step(60, 3, 60, 8);
    // redirect-heavy traffic with fast memory
    repeat (800) step(90, 1, 70, 30);
    // redirect-heavy traffic with slow memory
    repeat (600) step(50, 4, 50, 20);
    // reset while a request is outstanding
    for (int i = 0; i < 50 && !outst; i++) step(100, 4, 50, 0);
    chk("outstanding_before_reset", 32'(outst), 32'd1);
    do_reset();
    repeat (200) step(70, 3, 60, 10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
